// File: rtl/control_sequencer_if.sv
// Strobe bundle between control_sequencer (master) and the Datapath (slave).
// Start/IR flow into the sequencer; every register-transfer strobe flows out.
interface control_sequencer_if;
    logic        Start;
    logic [31:0] IR;
    logic        PCout, Zhighout, Zlowout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin;
    logic        IncPC, Read;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic        LOin, HIin;
    logic [4:0]  alu_op;
    logic        Run;
    logic        illegal_op;

    modport master (
        input  Start, IR,
        output PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, LOin, HIin, alu_op, Run, illegal_op
    );

    modport slave (
        output Start, IR,
        input  PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, LOin, HIin, alu_op, Run, illegal_op
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving the Datapath strobes.
// Define SEQ_MULDIV_EN to enable the MUL/DIV two-register ops (adds state T6).
module control_sequencer #(
    parameter logic [4:0] NOP_OPCODE  = 5'b11010,
    parameter logic [4:0] HALT_OPCODE = 5'b11011,
    parameter logic [4:0] ALU_LO      = 5'b00011,
    parameter logic [4:0] ALU_HI      = 5'b01100
) (
    input logic                 Clock,
    input logic                 Clear,
    control_sequencer_if.master ctrl
);

`ifdef SEQ_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif
    localparam logic [4:0] MUL_OPCODE = 5'b01111;
    localparam logic [4:0] DIV_OPCODE = 5'b10000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_HALTED = 4'd8
    } state_t;

    typedef struct packed {
        logic       pc_out, zhigh_out, zlow_out, mdr_out;
        logic       mar_in, pc_in, mdr_in, ir_in, y_in, z_in;
        logic       inc_pc, read;
        logic       gra, grb, grc, r_in, r_out;
        logic       lo_in, hi_in;
        logic       illegal_op, run;
        logic [4:0] alu_op;
    } ctrl_t;

    state_t     state_r;
    state_t     next_state_s;
    ctrl_t      ctrl_r;
    ctrl_t      t3_ctrl_s;
    ctrl_t      ctrl_s;
    logic [4:0] opcode_s;
    logic       unused_ir_s;

    assign opcode_s    = ctrl.IR[31:27];
    // Register fields are decoded downstream from Gra/Grb/Grc.
    assign unused_ir_s = ^ctrl.IR[26:0];

    function automatic logic is_alu(input logic [4:0] op);
        return (op >= ALU_LO) && (op <= ALU_HI);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return MULDIV_EN && ((op == MUL_OPCODE) || (op == DIV_OPCODE));
    endfunction

    // Strobes of every state except the IR-dependent part of T3.
    function automatic ctrl_t state_strobes(input state_t st, input logic [4:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; c.run = 1'b1;
            end
            S_T1: begin
                c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; c.run = 1'b1;
            end
            S_T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1; c.run = 1'b1;
            end
            S_T3: c.run = 1'b1;
            S_T4: begin
                c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op; c.run = 1'b1;
                if (is_muldiv(op)) c.grb = 1'b1;
                else               c.grc = 1'b1;
            end
            S_T5: begin
                c.zlow_out = 1'b1; c.run = 1'b1;
                if (is_muldiv(op)) c.lo_in = 1'b1;
                else begin
                    c.gra  = 1'b1;
                    c.r_in = 1'b1;
                end
            end
            S_T6: begin
                c.zhigh_out = 1'b1; c.hi_in = 1'b1; c.run = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t t3_strobes(input logic [4:0] op);
        ctrl_t c;
        c = '0;
        if (is_alu(op)) begin
            c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if (is_muldiv(op)) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if ((op == NOP_OPCODE) || (op == HALT_OPCODE)) begin
            c = '0;
        end else begin
            c.illegal_op = 1'b1;
        end
        return c;
    endfunction

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (ctrl.Start) next_state_s = S_T0;
                else            next_state_s = S_IDLE;
            end
            S_T0: next_state_s = S_T1;
            S_T1: next_state_s = S_T2;
            S_T2: next_state_s = S_T3;
            S_T3: begin
                if (is_alu(opcode_s) || is_muldiv(opcode_s)) next_state_s = S_T4;
                else if (opcode_s == HALT_OPCODE)            next_state_s = S_HALTED;
                else                                         next_state_s = S_T0;
            end
            S_T4: next_state_s = S_T5;
            S_T5: begin
                if (is_muldiv(opcode_s)) next_state_s = S_T6;
                else                     next_state_s = S_T0;
            end
            S_T6:     next_state_s = S_T0;
            S_HALTED: next_state_s = S_HALTED;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // State register with strobes pre-decoded for the state being entered.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_r <= S_IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= state_strobes(next_state_s, opcode_s);
        end
    end

    // IR is only loaded at the end of T2, so the T3 decode cannot be pre-registered.
    always_comb begin
        if (state_r == S_T3) t3_ctrl_s = t3_strobes(opcode_s);
        else                 t3_ctrl_s = '0;
        ctrl_s = ctrl_r | t3_ctrl_s;
    end

    assign ctrl.PCout      = ctrl_s.pc_out;
    assign ctrl.Zhighout   = ctrl_s.zhigh_out;
    assign ctrl.Zlowout    = ctrl_s.zlow_out;
    assign ctrl.MDRout     = ctrl_s.mdr_out;
    assign ctrl.MARin      = ctrl_s.mar_in;
    assign ctrl.PCin       = ctrl_s.pc_in;
    assign ctrl.MDRin      = ctrl_s.mdr_in;
    assign ctrl.IRin       = ctrl_s.ir_in;
    assign ctrl.Yin        = ctrl_s.y_in;
    assign ctrl.Zin        = ctrl_s.z_in;
    assign ctrl.IncPC      = ctrl_s.inc_pc;
    assign ctrl.Read       = ctrl_s.read;
    assign ctrl.Gra        = ctrl_s.gra;
    assign ctrl.Grb        = ctrl_s.grb;
    assign ctrl.Grc        = ctrl_s.grc;
    assign ctrl.Rin        = ctrl_s.r_in;
    assign ctrl.Rout       = ctrl_s.r_out;
    assign ctrl.LOin       = ctrl_s.lo_in;
    assign ctrl.HIin       = ctrl_s.hi_in;
    assign ctrl.alu_op     = ctrl_s.alu_op;
    assign ctrl.Run        = ctrl_s.run;
    assign ctrl.illegal_op = ctrl_s.illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; outputs sampled on the falling edge.
// Expectations for opcode 01111 follow SEQ_MULDIV_EN.
module tb_control_sequencer;

    logic Clock = 1'b0;
    logic Clear = 1'b0;
    int   checks = 0;
    int   failures = 0;

    control_sequencer_if bus();

    control_sequencer dut (
        .Clock (Clock),
        .Clear (Clear),
        .ctrl  (bus)
    );

    always #5 Clock = ~Clock;

    localparam logic [25:0] B_PCOUT  = 26'd1 << 25;
    localparam logic [25:0] B_ZHIGH  = 26'd1 << 24;
    localparam logic [25:0] B_ZLOW   = 26'd1 << 23;
    localparam logic [25:0] B_MDROUT = 26'd1 << 22;
    localparam logic [25:0] B_MARIN  = 26'd1 << 21;
    localparam logic [25:0] B_PCIN   = 26'd1 << 20;
    localparam logic [25:0] B_MDRIN  = 26'd1 << 19;
    localparam logic [25:0] B_IRIN   = 26'd1 << 18;
    localparam logic [25:0] B_YIN    = 26'd1 << 17;
    localparam logic [25:0] B_ZIN    = 26'd1 << 16;
    localparam logic [25:0] B_INCPC  = 26'd1 << 15;
    localparam logic [25:0] B_READ   = 26'd1 << 14;
    localparam logic [25:0] B_GRA    = 26'd1 << 13;
    localparam logic [25:0] B_GRB    = 26'd1 << 12;
    localparam logic [25:0] B_GRC    = 26'd1 << 11;
    localparam logic [25:0] B_RIN    = 26'd1 << 10;
    localparam logic [25:0] B_ROUT   = 26'd1 << 9;
    localparam logic [25:0] B_LOIN   = 26'd1 << 8;
    localparam logic [25:0] B_HIIN   = 26'd1 << 7;
    localparam logic [25:0] B_ILL    = 26'd1 << 6;
    localparam logic [25:0] B_RUN    = 26'd1 << 5;

    localparam logic [25:0] F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [25:0] F1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [25:0] F2 = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [25:0] NONE = 26'd0;

    function automatic logic [25:0] obs();
        return {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.MARin, bus.PCin,
                bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.IncPC, bus.Read, bus.Gra,
                bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.LOin, bus.HIin, bus.illegal_op,
                bus.Run, bus.alu_op};
    endfunction

    task automatic do_clear();
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    // Leaves the bench at the falling edge inside T0.
    task automatic pulse_start();
        @(negedge Clock);
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Clear = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clock);
            if (i == 1) Clear = 1'b0;
            checks++;
            if (obs() !== NONE) begin
                failures++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs(), NONE);
            end
        end
    endtask

    task automatic test_alu(input logic [4:0] op, input bit hold_start);
        logic [25:0] exp_a [7];
        do_clear();
        bus.IR = {op, 4'd5, 4'd2, 4'd4, 15'd0};
        exp_a = '{F0, F1, F2, B_GRB | B_ROUT | B_YIN | B_RUN,
                  B_GRC | B_ROUT | B_ZIN | B_RUN | {21'd0, op},
                  B_ZLOW | B_GRA | B_RIN | B_RUN, F0};
        pulse_start();
        bus.Start = hold_start;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge Clock);
            checks++;
            if (obs() !== exp_a[i]) begin
                failures++;
                $display("FAIL alu op=%b step T%0d: got %h expected %h", op, i, obs(), exp_a[i]);
            end
        end
        bus.Start = 1'b0;
    endtask

    task automatic test_nop_illegal(input logic [4:0] op, input bit illegal);
        logic [25:0] exp_a [5];
        do_clear();
        bus.IR = {op, 27'd0};
        exp_a = '{F0, F1, F2, (illegal ? B_ILL : NONE) | B_RUN, F0};
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clock);
            checks++;
            if (obs() !== exp_a[i]) begin
                failures++;
                $display("FAIL short op=%b step %0d: got %h expected %h", op, i, obs(), exp_a[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [25:0] exp_a [5];
        do_clear();
        bus.IR = {5'b11011, 27'd0};
        exp_a = '{F0, F1, F2, B_RUN, NONE};
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clock);
            checks++;
            if (obs() !== exp_a[i]) begin
                failures++;
                $display("FAIL halt step %0d: got %h expected %h", i, obs(), exp_a[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            bus.Start = (i % 2 == 0);
            @(negedge Clock);
            checks++;
            if (obs() !== NONE) begin
                failures++;
                $display("FAIL halted_start cycle %0d: got %h expected %h", i, obs(), NONE);
            end
        end
        bus.Start = 1'b0;
        do_clear();
        checks++;
        if (obs() !== NONE) begin
            failures++;
            $display("FAIL halt_clear: got %h expected %h", obs(), NONE);
        end
        pulse_start();
        checks++;
        if (obs() !== F0) begin
            failures++;
            $display("FAIL halt_restart: got %h expected %h", obs(), F0);
        end
    endtask

    task automatic test_clear_start();
        do_clear();
        @(negedge Clock);
        Clear = 1'b1;
        bus.Start = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        bus.Start = 1'b0;
        checks++;
        if (obs() !== NONE) begin
            failures++;
            $display("FAIL clear_and_start: got %h expected %h", obs(), NONE);
        end
        @(negedge Clock);
        checks++;
        if (obs() !== NONE) begin
            failures++;
            $display("FAIL clear_and_start_idle: got %h expected %h", obs(), NONE);
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        bus.IR = 32'h1A920000;
        pulse_start();
        repeat (4) @(negedge Clock);
        checks++;
        if (obs() !== (B_GRC | B_ROUT | B_ZIN | B_RUN | 26'd3)) begin
            failures++;
            $display("FAIL clear_mid_t4: got %h expected %h", obs(), B_GRC | B_ROUT | B_ZIN | B_RUN | 26'd3);
        end
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge Clock);
            checks++;
            if (obs() !== NONE) begin
                failures++;
                $display("FAIL clear_mid cycle %0d: got %h expected %h", i, obs(), NONE);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [25:0] exp_a [8];
        int          n;
        do_clear();
        bus.IR = {5'b01111, 27'd0};
`ifdef SEQ_MULDIV_EN
        exp_a = '{F0, F1, F2, B_GRA | B_ROUT | B_YIN | B_RUN,
                  B_GRB | B_ROUT | B_ZIN | B_RUN | 26'd15,
                  B_ZLOW | B_LOIN | B_RUN, B_ZHIGH | B_HIIN | B_RUN, F0};
        n = 8;
`else
        exp_a = '{F0, F1, F2, B_ILL | B_RUN, F0, NONE, NONE, NONE};
        n = 5;
`endif
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge Clock);
            checks++;
            if (obs() !== exp_a[i]) begin
                failures++;
                $display("FAIL muldiv step %0d: got %h expected %h", i, obs(), exp_a[i]);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        bus.Start = 1'b0;
        bus.IR    = 32'd0;
        test_reset();
        test_alu(5'b00011, 1'b0);
        test_alu(5'b01100, 1'b1);
        test_nop_illegal(5'b11010, 1'b0);
        test_nop_illegal(5'b11111, 1'b1);
        test_nop_illegal(5'b00010, 1'b1);
        test_nop_illegal(5'b01101, 1'b1);
        test_halt();
        test_clear_start();
        test_clear_mid();
        test_muldiv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
